// File: rtl/raster_pkg.sv
// Shared types and default sizes for the Bresenham line rasterizer.
package raster_pkg;

  // Default screen coordinate widths (640 x 480).
  localparam int X_W_DEF = 10;
  localparam int Y_W_DEF = 9;

  // Coordinate wide enough for either axis at default sizes.
  typedef logic [X_W_DEF-1:0] coord_t;

  // Walk controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } raster_state_t;

endpackage : raster_pkg

// File: rtl/line_raster_unit.sv
// Bresenham line rasterizer: accepts one clipped segment, walks it one pixel
// per accepted cycle toward the frame buffer, then pulses seg_done.
module line_raster_unit
  import raster_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           seg_vld,
  input  logic [X_W-1:0] seg_x0,
  input  logic [X_W-1:0] seg_x1,
  input  logic [Y_W-1:0] seg_y0,
  input  logic [Y_W-1:0] seg_y1,
  input  logic [2:0]     seg_color,
  output logic           raster_ready,
  output logic           px_we,
  output logic [X_W-1:0] px_x,
  output logic [Y_W-1:0] px_y,
  output logic [2:0]     px_color,
  input  logic           fb_stall,
  output logic           seg_done
);

  // Error term width: widest coordinate plus sign and doubling headroom.
  localparam int E_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  raster_state_t          state_r, state_nxt_s;
  logic [X_W-1:0]         x_r, x1_r, x_nxt_s, dx_abs_s;
  logic [Y_W-1:0]         y_r, y1_r, y_nxt_s, dy_abs_s;
  logic [2:0]             color_r;
  logic                   sx_neg_r, sy_neg_r;
  logic signed [E_W-1:0]  dx_r, dy_r, err_r;
  logic signed [E_W-1:0]  dx_init_s, dy_mag_s, dy_init_s;
  logic signed [E_W-1:0]  e2_s, err_x_s, err_y_s, err_nxt_s;
  logic                   accept_s, last_s, step_x_s, step_y_s;
  logic                   ready_r, we_r, done_r;

  // Segment setup terms derived from the endpoints presented by the clipper.
  always_comb begin
    dx_abs_s  = (seg_x0 < seg_x1) ? (seg_x1 - seg_x0) : (seg_x0 - seg_x1);
    dy_abs_s  = (seg_y0 < seg_y1) ? (seg_y1 - seg_y0) : (seg_y0 - seg_y1);
    dx_init_s = $signed({{(E_W-X_W){1'b0}}, dx_abs_s});
    dy_mag_s  = $signed({{(E_W-Y_W){1'b0}}, dy_abs_s});
    dy_init_s = -dy_mag_s;
  end

  // One Bresenham step; both axis steps may fire and their error terms add.
  always_comb begin
    accept_s  = (state_r == DRAW) && !fb_stall;
    last_s    = (x_r == x1_r) && (y_r == y1_r);
    e2_s      = err_r <<< 1;
    step_x_s  = (e2_s >= dy_r);
    step_y_s  = (e2_s <= dx_r);
    err_x_s   = step_x_s ? dy_r : {E_W{1'b0}};
    err_y_s   = step_y_s ? dx_r : {E_W{1'b0}};
    err_nxt_s = err_r + err_x_s + err_y_s;
    if (step_x_s) begin
      x_nxt_s = sx_neg_r ? (x_r - X_ONE) : (x_r + X_ONE);
    end else begin
      x_nxt_s = x_r;
    end
    if (step_y_s) begin
      y_nxt_s = sy_neg_r ? (y_r - Y_ONE) : (y_r + Y_ONE);
    end else begin
      y_nxt_s = y_r;
    end
  end

  // Next-state decision for the IDLE/DRAW/DONE walk controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (seg_vld) begin
          state_nxt_s = DRAW;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAW: begin
        if (accept_s && last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAW;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus registered handshake/strobe outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
      we_r    <= (state_nxt_s == DRAW);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Walk datapath: latch the segment in IDLE, advance only on an accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r      <= {X_W{1'b0}};
      y_r      <= {Y_W{1'b0}};
      x1_r     <= {X_W{1'b0}};
      y1_r     <= {Y_W{1'b0}};
      color_r  <= 3'd0;
      sx_neg_r <= 1'b0;
      sy_neg_r <= 1'b0;
      dx_r     <= {E_W{1'b0}};
      dy_r     <= {E_W{1'b0}};
      err_r    <= {E_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (seg_vld) begin
            x_r      <= seg_x0;
            y_r      <= seg_y0;
            x1_r     <= seg_x1;
            y1_r     <= seg_y1;
            color_r  <= seg_color;
            sx_neg_r <= !(seg_x0 < seg_x1);
            sy_neg_r <= !(seg_y0 < seg_y1);
            dx_r     <= dx_init_s;
            dy_r     <= dy_init_s;
            err_r    <= dx_init_s + dy_init_s;
          end
        end
        DRAW: begin
          if (accept_s && !last_s) begin
            x_r   <= x_nxt_s;
            y_r   <= y_nxt_s;
            err_r <= err_nxt_s;
          end
        end
        default: begin
          x_r <= x_r;
        end
      endcase
    end
  end

  assign raster_ready = ready_r;
  assign px_we        = we_r;
  assign px_x         = x_r;
  assign px_y         = y_r;
  assign px_color     = color_r;
  assign seg_done     = done_r;

endmodule : line_raster_unit

// File: tb/tb_line_raster_unit.sv
// Scoreboard bench for line_raster_unit: stimulus pushes expected pixels and
// done events; a negedge monitor pops and compares against DUT output.
module tb_line_raster_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seg_vld = 1'b0;
  logic [9:0] seg_x0 = 10'd0, seg_x1 = 10'd0;
  logic [8:0] seg_y0 = 9'd0, seg_y1 = 9'd0;
  logic [2:0] seg_color = 3'd0;
  logic       raster_ready, px_we, seg_done;
  logic [9:0] px_x;
  logic [8:0] px_y;
  logic [2:0] px_color;
  logic       fb_stall = 1'b0;

  typedef struct {
    bit         is_done;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_cyc = 0;

  line_raster_unit #(.X_W(10), .Y_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .seg_vld(seg_vld),
    .seg_x0(seg_x0), .seg_x1(seg_x1), .seg_y0(seg_y0), .seg_y1(seg_y1),
    .seg_color(seg_color), .raster_ready(raster_ready), .px_we(px_we),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .fb_stall(fb_stall),
    .seg_done(seg_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_px(input int x, input int y, input int c);
    exp_t e;
    e.is_done = 1'b0; e.x = 10'(x); e.y = 9'(y); e.c = 3'(c); e.lat = 0;
    sb.push_back(e);
  endtask

  task automatic push_done(input int lat);
    exp_t e;
    e.is_done = 1'b1; e.x = 10'd0; e.y = 9'd0; e.c = 3'd0; e.lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: compares every accepted pixel, held stalled pixel and done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (seg_vld && raster_ready) hs_cyc = cyc;
      if (px_we && fb_stall && sb.size() > 0 && !sb[0].is_done) begin
        check("stall_hold_x", int'(px_x), int'(sb[0].x));
        check("stall_hold_y", int'(px_y), int'(sb[0].y));
      end
      if (px_we && !fb_stall) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("px_x", int'(px_x), int'(e.x));
          check("px_y", int'(px_y), int'(e.y));
          check("px_color", int'(px_color), int'(e.c));
        end
      end
      if (seg_done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          check("unexpected_seg_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("seg_done_latency", cyc - hs_cyc, e.lat);
          check("ready_low_at_done", int'(raster_ready), 0);
          check("we_low_at_done", int'(px_we), 0);
        end
      end
    end
  end

  // Drive one segment once the unit reports ready; returns in cycle N+1.
  task automatic send_seg(input int x0, input int y0, input int x1, input int y1,
                          input int c);
    int n = 0;
    @(posedge clk); #1;
    while (!raster_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!raster_ready) check("ready_timeout", 0, 1);
    seg_x0 = 10'(x0); seg_y0 = 9'(y0);
    seg_x1 = 10'(x1); seg_y1 = 9'(y1);
    seg_color = 3'(c);
    seg_vld = 1'b1;
    @(posedge clk); #1;
    seg_vld = 1'b0;
  endtask

  // Wait for the scoreboard to drain and the unit to return to ready.
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !raster_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #12;
    check("rst_ready", int'(raster_ready), 1);
    check("rst_px_we", int'(px_we), 0);
    check("rst_px_x", int'(px_x), 0);
    check("rst_px_y", int'(px_y), 0);
    check("rst_px_color", int'(px_color), 0);
    check("rst_seg_done", int'(seg_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Horizontal line.
    push_px(0, 0, 5); push_px(1, 0, 5); push_px(2, 0, 5); push_px(3, 0, 5);
    push_done(5);
    send_seg(0, 0, 3, 0, 5);
    wait_idle();

    // Steep line.
    push_px(0, 0, 2); push_px(0, 1, 2); push_px(1, 2, 2); push_px(1, 3, 2);
    push_done(5);
    send_seg(0, 0, 1, 3, 2);
    wait_idle();

    // Negative direction.
    push_px(5, 5, 7); push_px(4, 4, 7); push_px(3, 3, 7); push_px(2, 2, 7);
    push_done(5);
    send_seg(5, 5, 2, 2, 7);
    wait_idle();

    // Degenerate point at the far screen corner.
    push_px(639, 479, 1);
    push_done(2);
    send_seg(639, 479, 639, 479, 1);
    wait_idle();

    // Stall for three cycles while (1,0) is presented.
    push_px(0, 0, 5); push_px(1, 0, 5); push_px(2, 0, 5); push_px(3, 0, 5);
    push_done(8);
    send_seg(0, 0, 3, 0, 5);
    @(posedge clk); #1;
    fb_stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    fb_stall = 1'b0;
    wait_idle();

    // Reset while (2,0) of a long line is presented.
    push_px(0, 0, 6); push_px(1, 0, 6);
    send_seg(0, 0, 9, 0, 6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_px_x", int'(px_x), 2);
    rst_n = 1'b0;
    #1;
    check("reset_mid_we", int'(px_we), 0);
    check("reset_mid_ready", int'(raster_ready), 1);
    check("reset_mid_done", int'(seg_done), 0);
    check("reset_mid_sb_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();

    // Shallow line accepted after reset release.
    push_px(2, 1, 3); push_px(3, 2, 3); push_px(4, 2, 3); push_px(5, 3, 3);
    push_px(6, 3, 3);
    push_done(6);
    send_seg(2, 1, 6, 3, 3);
    wait_idle();

    repeat (3) @(posedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_line_raster_unit
